// File: rtl/sdram_pkg.sv
// Shared SDR SDRAM definitions: command encoding, mode-register fields and burst helpers.
package sdram_pkg;

  typedef enum logic [2:0] {
    CMD_LOAD_MODE  = 3'b000,
    CMD_REFRESH    = 3'b001,
    CMD_PRECHARGE  = 3'b010,
    CMD_ACTIVE     = 3'b011,
    CMD_WRITE      = 3'b100,
    CMD_READ       = 3'b101,
    CMD_BURST_TERM = 3'b110,
    CMD_NOP        = 3'b111
  } sdram_cmd_e;

  localparam int unsigned MODE_BL_LSB = 0;
  localparam int unsigned MODE_CL_LSB = 4;

  localparam logic [2:0] BL_CODE_1 = 3'b000;
  localparam logic [2:0] BL_CODE_2 = 3'b001;
  localparam logic [2:0] BL_CODE_4 = 3'b010;
  localparam logic [2:0] BL_CODE_8 = 3'b011;
  localparam logic [2:0] CL_CODE_2 = 3'b010;
  localparam logic [2:0] CL_CODE_3 = 3'b011;

  function automatic logic [3:0] decode_bl(input logic [2:0] code);
    case (code)
      BL_CODE_2: return 4'd2;
      BL_CODE_4: return 4'd4;
      BL_CODE_8: return 4'd8;
      default:   return 4'd1;
    endcase
  endfunction

  function automatic logic [1:0] decode_cl(input logic [2:0] code);
    return (code == CL_CODE_2) ? 2'd2 : 2'd3;
  endfunction

  function automatic logic cl_code_valid(input logic [2:0] code);
    return (code == CL_CODE_2) || (code == CL_CODE_3);
  endfunction

  // Sequential burst: the low log2(BL) column bits count and wrap inside the aligned block.
  function automatic logic [8:0] burst_column(input logic [8:0] start, input logic [3:0] bl,
                                              input logic [2:0] k);
    logic [8:0] m;
    m = {5'd0, bl} - 9'd1;
    return (start & ~m) | ((start + {6'd0, k}) & m);
  endfunction

endpackage

// File: rtl/sdram_model_mem.sv
// Word storage for the SDRAM model: one byte-enabled write port, one synchronous read port.
module sdram_model_mem #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [1:0]        byte_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [15:0]       rd_data
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (byte_en[0]) mem[wr_addr][7:0]  <= wr_data[7:0];
      if (byte_en[1]) mem[wr_addr][15:8] <= wr_data[15:8];
    end
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sdram_device_model.sv
// x16 SDR SDRAM device responder: command decode, bank rows, CL/BL bursts, masked writes.
// Define SDRAM_MODEL_PROTO_CHECK_EN to build the sticky protocol checker behind proto_err.
module sdram_device_model
  import sdram_pkg::*;
#(
  parameter int unsigned ROW_KEEP = 3,
  parameter int unsigned COL_KEEP = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] addr,
  input  logic [1:0]  bank_addr,
  inout  wire  [15:0] data,
  input  logic        clock_enable,
  input  logic        cs_n,
  input  logic        ras_n,
  input  logic        cas_n,
  input  logic        we_n,
  input  logic        data_mask_low,
  input  logic        data_mask_high,
  output logic        mode_loaded,
  output logic        proto_err
);
  localparam int unsigned ADDR_W = 2 + ROW_KEEP + COL_KEEP;

  sdram_cmd_e          cmd;
  logic [3:0]          bank_open;
  logic [ROW_KEEP-1:0] bank_row [4];
  logic [3:0]          bl;
  logic                cl3;
  logic                burst_active, burst_write, burst_ap;
  logic [1:0]          burst_bank;
  logic [8:0]          burst_col;
  logic [2:0]          burst_k;
  logic [3:0]          burst_bl;
  logic                is_rw, truncate, burst_step, burst_last;
  logic [1:0]          xfer_bank;
  logic [8:0]          xfer_col;
  logic [ADDR_W-1:0]   mem_addr;
  logic                wr_en, rd_issue;
  logic [15:0]         rd_data;
  logic                s1_v, s1_cl3, s2_v, out_v;
  logic [15:0]         s2_d, out_d;

  always_comb begin
    cmd = CMD_NOP;
    if (clock_enable && !cs_n) cmd = sdram_cmd_e'({ras_n, cas_n, we_n});
  end

  always_comb begin
    is_rw      = (cmd == CMD_READ) || (cmd == CMD_WRITE);
    truncate   = burst_active && (is_rw || cmd == CMD_BURST_TERM ||
                 (cmd == CMD_PRECHARGE && (addr[10] || bank_addr == burst_bank)));
    burst_step = clock_enable && burst_active && !truncate;
    burst_last = burst_step && ({1'b0, burst_k} == burst_bl - 4'd1);
    xfer_bank  = is_rw ? bank_addr : burst_bank;
    xfer_col   = is_rw ? addr[8:0] : burst_column(burst_col, burst_bl, burst_k);
    mem_addr   = {xfer_bank, bank_row[xfer_bank], xfer_col[COL_KEEP-1:0]};
    wr_en      = rst_n && ((cmd == CMD_WRITE) || (burst_step && burst_write));
    rd_issue   = rst_n && ((cmd == CMD_READ) || (burst_step && !burst_write));
  end

  sdram_model_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .byte_en ({~data_mask_high, ~data_mask_low}),
    .wr_addr (mem_addr),
    .wr_data (data),
    .rd_en   (rd_issue),
    .rd_addr (mem_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_open    <= '0;
      burst_active <= 1'b0;
      s1_v         <= 1'b0;
      s2_v         <= 1'b0;
      out_v        <= 1'b0;
      mode_loaded  <= 1'b0;
      bl           <= 4'd1;
      cl3          <= 1'b1;
    end else if (clock_enable) begin
      if (cmd == CMD_LOAD_MODE) begin
        mode_loaded <= 1'b1;
        bl          <= decode_bl(addr[MODE_BL_LSB +: 3]);
        cl3         <= (decode_cl(addr[MODE_CL_LSB +: 3]) == 2'd3);
      end
      // Auto-precharge at burst end first, so a same-edge command to that bank wins.
      if (burst_last && burst_ap) bank_open[burst_bank] <= 1'b0;
      if (cmd == CMD_ACTIVE) begin
        bank_open[bank_addr] <= 1'b1;
        bank_row[bank_addr]  <= addr[ROW_KEEP-1:0];
      end
      if (cmd == CMD_PRECHARGE) begin
        if (addr[10]) bank_open <= '0;
        else bank_open[bank_addr] <= 1'b0;
      end
      if (is_rw) begin
        burst_active <= (bl != 4'd1);
        burst_write  <= (cmd == CMD_WRITE);
        burst_bank   <= bank_addr;
        burst_col    <= addr[8:0];
        burst_bl     <= bl;
        burst_ap     <= addr[10];
        burst_k      <= 3'd1;
        if (bl == 4'd1 && addr[10]) bank_open[bank_addr] <= 1'b0;
      end else if (truncate || burst_last) begin
        burst_active <= 1'b0;
      end else if (burst_step) begin
        burst_k <= burst_k + 3'd1;
      end
      s1_v   <= rd_issue;
      s1_cl3 <= cl3;
      s2_v   <= s1_v && s1_cl3;
      s2_d   <= rd_data;
      out_v  <= s2_v || (s1_v && !s1_cl3);
      out_d  <= s2_v ? s2_d : rd_data;
      if (cmd == CMD_WRITE) begin
        s1_v  <= 1'b0;
        s2_v  <= 1'b0;
        out_v <= 1'b0;
      end
    end
  end

  // The bus is also released during the WRITE command cycle so word 0 is never contended.
  assign data = (out_v && cmd != CMD_WRITE) ? out_d : 'z;

`ifdef SDRAM_MODEL_PROTO_CHECK_EN
  logic proto_hit;

  always_comb begin
    proto_hit = 1'b0;
    if (cmd == CMD_ACTIVE && bank_open[bank_addr]) proto_hit = 1'b1;
    if (is_rw && !bank_open[bank_addr]) proto_hit = 1'b1;
    if ((cmd == CMD_ACTIVE || is_rw) && !mode_loaded) proto_hit = 1'b1;
    if ((cmd == CMD_REFRESH || cmd == CMD_LOAD_MODE) && |bank_open) proto_hit = 1'b1;
    if (cmd == CMD_LOAD_MODE && !cl_code_valid(addr[MODE_CL_LSB +: 3])) proto_hit = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) proto_err <= 1'b0;
    else if (proto_hit) proto_err <= 1'b1;
  end
`else
  assign proto_err = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{addr, xfer_col};

endmodule

// File: tb/tb_sdram_device_model.sv
// Directed self-checking bench for sdram_device_model: bursts, masks, CL, interruption, reset.
module tb_sdram_device_model;

  localparam logic [2:0] C_LMR = 3'b000;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_BT  = 3'b110;

`ifdef SDRAM_MODEL_PROTO_CHECK_EN
  localparam logic PROTO_EXP = 1'b1;
`else
  localparam logic PROTO_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, clock_enable, cs_n, ras_n, cas_n, we_n;
  logic        data_mask_low, data_mask_high;
  logic [12:0] addr;
  logic [1:0]  bank_addr;
  logic        mode_loaded, proto_err;
  logic [15:0] tb_d;
  logic        tb_oe;
  wire  [15:0] data;

  int n_checks = 0;
  int n_fail   = 0;

  assign data = tb_oe ? tb_d : 'z;

  always #5 clk = ~clk;

  sdram_device_model #(.ROW_KEEP(3), .COL_KEEP(5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .addr           (addr),
    .bank_addr      (bank_addr),
    .data           (data),
    .clock_enable   (clock_enable),
    .cs_n           (cs_n),
    .ras_n          (ras_n),
    .cas_n          (cas_n),
    .we_n           (we_n),
    .data_mask_low  (data_mask_low),
    .data_mask_high (data_mask_high),
    .mode_loaded    (mode_loaded),
    .proto_err      (proto_err)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic nop();
    cs_n = 1'b1;
    {ras_n, cas_n, we_n} = 3'b111;
  endtask

  task automatic drive(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a);
    cs_n = 1'b0;
    {ras_n, cas_n, we_n} = c;
    bank_addr = b;
    addr = a;
  endtask

  task automatic cmd(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a);
    drive(c, b, a);
    step();
    nop();
  endtask

  task automatic wr1(input logic [12:0] col, input logic [15:0] d, input logic mh, input logic ml);
    drive(C_WR, 2'd3, col);
    tb_d = d;
    tb_oe = 1'b1;
    data_mask_high = mh;
    data_mask_low = ml;
    step();
    nop();
    tb_oe = 1'b0;
    data_mask_high = 1'b0;
    data_mask_low = 1'b0;
  endtask

  // CL2 single-word read of bank 3; the word is on the bus one cycle after the command.
  task automatic rd1(input string tag, input logic [12:0] col, input logic [15:0] exp);
    cmd(C_RD, 2'd3, col);
    step();
    check(tag, data, exp);
  endtask

  task automatic setup_mode(input logic [12:0] mode);
    cmd(C_PRE, 2'd0, 13'h400);
    cmd(C_LMR, 2'd0, mode);
    cmd(C_ACT, 2'd3, 13'h1FDB);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clock_enable = 1'b1; nop();
    addr = '0; bank_addr = '0; data_mask_low = 1'b0; data_mask_high = 1'b0;
    tb_oe = 1'b1; tb_d = '0;
    repeat (3) step();
    check("rst_bus", data, 16'h0000);
    check("rst_mode_loaded", {15'd0, mode_loaded}, 16'd0);
    check("rst_proto_err", {15'd0, proto_err}, 16'd0);
    tb_oe = 1'b0;
    rst_n = 1'b1;
    step();

    // CL2 BL1 single word round trip
    cmd(C_LMR, 2'd0, 13'h020);
    cmd(C_ACT, 2'd3, 13'h1FDB);
    wr1(13'h0ED, 16'h0D05, 1'b0, 1'b0);
    cmd(C_RD, 2'd3, 13'h0ED);
    step();
    check("t1_read", data, 16'h0D05);
    check("t1_mode_loaded", {15'd0, mode_loaded}, 16'd1);
    check("t1_proto_err", {15'd0, proto_err}, 16'd0);
    tb_oe = 1'b1; tb_d = '0;
    step();
    check("t1_release", data, 16'h0000);
    tb_oe = 1'b0;

    // CL3 BL4 wrapped burst, with a two-cycle CKE freeze after word 0
    setup_mode(13'h032);
    drive(C_WR, 2'd3, 13'h006);
    tb_oe = 1'b1; tb_d = 16'h00A0;
    step(); nop();
    tb_d = 16'h00A1; step();
    tb_d = 16'h00A2; step();
    tb_d = 16'h00A3; step();
    tb_oe = 1'b0;
    cmd(C_RD, 2'd3, 13'h004);
    step(); step();
    check("t2_w0", data, 16'h00A2);
    clock_enable = 1'b0;
    step();
    check("t2_freeze1", data, 16'h00A2);
    step();
    check("t2_freeze2", data, 16'h00A2);
    clock_enable = 1'b1;
    step();
    check("t2_w1", data, 16'h00A3);
    step();
    check("t2_w2", data, 16'h00A0);
    step();
    check("t2_w3", data, 16'h00A1);
    tb_oe = 1'b1; tb_d = '0;
    step();
    check("t2_release", data, 16'h0000);
    tb_oe = 1'b0;

    // Byte masks
    setup_mode(13'h020);
    wr1(13'h010, 16'hBBBB, 1'b0, 1'b0);
    wr1(13'h010, 16'h1234, 1'b1, 1'b0);
    rd1("t3_mask_high", 13'h010, 16'hBB34);
    wr1(13'h010, 16'h5678, 1'b0, 1'b1);
    rd1("t3_mask_low", 13'h010, 16'h5634);

    // BL8 CL2 read interrupted by a WRITE three cycles after the READ
    setup_mode(13'h023);
    drive(C_WR, 2'd3, 13'h008);
    tb_oe = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tb_d = 16'(16'h1100 + k);
      step();
      if (k == 0) nop();
    end
    tb_oe = 1'b0;
    cmd(C_RD, 2'd3, 13'h008);
    step();
    check("t4_w0", data, 16'h1100);
    step();
    check("t4_w1", data, 16'h1101);
    drive(C_WR, 2'd3, 13'h020);
    tb_d = 16'hCAFE; tb_oe = 1'b1;
    step();
    drive(C_BT, 2'd0, 13'h000);
    tb_d = '0;
    #1;
    check("t4_release_write_edge", data, 16'h0000);
    step(); nop();
    check("t4_release_next", data, 16'h0000);
    tb_oe = 1'b0;
    rd1("t4_write_word", 13'h020, 16'hCAFE);
    check("t4_proto_err", {15'd0, proto_err}, 16'd0);

    // READ to a closed bank
    cmd(C_RD, 2'd0, 13'h000);
    check("t5_proto_set", {15'd0, proto_err}, {15'd0, PROTO_EXP});
    step(); step();
    check("t5_proto_sticky", {15'd0, proto_err}, {15'd0, PROTO_EXP});
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("t5_proto_reset", {15'd0, proto_err}, 16'd0);
    check("t5_mode_reset", {15'd0, mode_loaded}, 16'd0);

    // Reset in the middle of a read burst
    cmd(C_LMR, 2'd0, 13'h023);
    cmd(C_ACT, 2'd3, 13'h1FDB);
    cmd(C_RD, 2'd3, 13'h008);
    step();
    check("t6_w0", data, 16'h1100);
    rst_n = 1'b0;
    tb_oe = 1'b1; tb_d = '0;
    step();
    check("t6_bus_after_reset", data, 16'h0000);
    check("t6_mode_after_reset", {15'd0, mode_loaded}, 16'd0);
    rst_n = 1'b1;
    tb_oe = 1'b0;
    step();
    cmd(C_RD, 2'd3, 13'h008);
    check("t6_proto_closed", {15'd0, proto_err}, {15'd0, PROTO_EXP});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
